// File: rtl/kinase_ctrl_pkg.sv
// kinase_ctrl_pkg: opcodes, group widths, pump phase tables and FSM states for the valve sequencer
package kinase_ctrl_pkg;
    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_PUMP_A = 2'd1;
    localparam logic [1:0] OP_PUMP_B = 2'd2;
    localparam logic [1:0] OP_FLUSH  = 2'd3;
    localparam int CTRL_A_W = 13;
    localparam int CTRL_S_W = 4;
    localparam int PUMP_A_W = 3;
    localparam int PUMP_B_W = 2;
    localparam int PUMP_A_N = 6;
    localparam int PUMP_B_N = 2;
    localparam logic [PUMP_A_W-1:0] PUMP_A_SEQ [PUMP_A_N] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    localparam logic [PUMP_B_W-1:0] PUMP_B_SEQ [PUMP_B_N] = '{2'b10, 2'b01};
    localparam logic [PUMP_A_W-1:0] PUMP_A_IDLE = '1;
    localparam logic [PUMP_B_W-1:0] PUMP_B_IDLE = '1;
    typedef enum logic [1:0] {S_IDLE, S_PUMP_A, S_PUMP_B, S_FLUSH} state_t;
endpackage

// File: rtl/pump_phase_gen.sv
// pump_phase_gen: dwell/phase/stroke sequencing for one peristaltic pump
module pump_phase_gen #(
    parameter int NPHASE = 6,
    parameter int STEP_CYCLES = 1000,
    parameter int CNT_W = 16,
    localparam int PW = NPHASE > 1 ? $clog2(NPHASE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             last,
    output logic             done
);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST = PW'(NPHASE - 1);
    logic run, wrap, pwrap;
    logic [CNT_W-1:0] dwell, strokes, tgt_m1;
    logic [PW-1:0] ph;
    // phase is the index that takes effect after the coming edge, so the owner can register its pattern
    always_comb begin
        wrap = run && dwell == STEP_LAST;
        pwrap = wrap && ph == PH_LAST;
        last = pwrap && strokes == tgt_m1;
        phase = (start || pwrap) ? '0 : wrap ? ph + 1'b1 : ph;
    end
    // counters; the stroke target is kept as N-1 so the full CNT_W range completes without wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            dwell <= '0;
            ph <= '0;
            strokes <= '0;
            tgt_m1 <= '0;
            done <= 1'b0;
        end else begin
            run <= start || (run && !abort && !last);
            dwell <= (start || wrap) ? '0 : run ? dwell + 1'b1 : dwell;
            ph <= phase;
            strokes <= start ? '0 : pwrap ? strokes + 1'b1 : strokes;
            if (start) tgt_m1 <= count - 1'b1;
            done <= last && !abort;
        end
    end
endmodule

// File: rtl/kinase_valve_sequencer.sv
// kinase_valve_sequencer: command-driven valve load, pump runs and line flush for the kinase_activity array
module kinase_valve_sequencer
    import kinase_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 1000,
    parameter int FLUSH_CYCLES = 5000,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [16:0]         cmd_arg,
    input  logic                abort,
    output logic [CTRL_A_W-1:0] ctrl_a,
    output logic [CTRL_S_W-1:0] ctrl_s,
    output logic [PUMP_A_W-1:0] pump_a,
    output logic [PUMP_B_W-1:0] pump_b,
    output logic                flush_en,
    output logic                busy,
    output logic                done
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    state_t state, state_d;
    logic accept, a_start, b_start, a_last, b_last, a_done, b_done, f_last, done_q;
    logic [CNT_W-1:0] stroke_n;
    logic [2:0] a_phase;
    logic [0:0] b_phase;
    logic [FW-1:0] fcnt;
    logic [CTRL_A_W-1:0] load_a;
    logic [CTRL_S_W-1:0] load_s;

    pump_phase_gen #(.NPHASE(PUMP_A_N), .STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_gen_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(abort), .count(stroke_n),
        .phase(a_phase), .last(a_last), .done(a_done)
    );
    pump_phase_gen #(.NPHASE(PUMP_B_N), .STEP_CYCLES(STEP_CYCLES), .CNT_W(CNT_W)) u_gen_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(abort), .count(stroke_n),
        .phase(b_phase), .last(b_last), .done(b_done)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else state <= state_d;
    end

    // next state; a zero-stroke pump command never leaves IDLE
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (accept) state_d = cmd_op == OP_FLUSH ? S_FLUSH : a_start ? S_PUMP_A : b_start ? S_PUMP_B : S_IDLE;
            S_PUMP_A: if (abort || a_last) state_d = S_IDLE;
            S_PUMP_B: if (abort || b_last) state_d = S_IDLE;
            default:  if (abort || f_last) state_d = S_IDLE;
        endcase
    end

    // handshake and decoded status
    always_comb begin
        cmd_ready = state == S_IDLE;
        busy = !cmd_ready;
        accept = cmd_valid && cmd_ready;
        stroke_n = cmd_arg[CNT_W-1:0];
        a_start = accept && cmd_op == OP_PUMP_A && stroke_n != '0;
        b_start = accept && cmd_op == OP_PUMP_B && stroke_n != '0;
        f_last = state == S_FLUSH && fcnt == FW'(FLUSH_CYCLES - 1);
        done = done_q || a_done || b_done;
    end

    // registered outputs built from the next state so patterns appear one cycle after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_a <= '0;
            load_s <= '0;
            ctrl_a <= '0;
            ctrl_s <= '0;
            pump_a <= PUMP_A_IDLE;
            pump_b <= PUMP_B_IDLE;
            flush_en <= 1'b0;
            fcnt <= '0;
            done_q <= 1'b0;
        end else begin
            if (accept && cmd_op == OP_LOAD) {load_s, load_a} <= cmd_arg;
            {ctrl_s, ctrl_a} <= state_d == S_FLUSH ? '1 : (accept && cmd_op == OP_LOAD) ? cmd_arg : {load_s, load_a};
            pump_a <= state_d == S_FLUSH ? '1 : state_d == S_PUMP_A ? PUMP_A_SEQ[a_phase] : PUMP_A_IDLE;
            pump_b <= state_d == S_FLUSH ? '1 : state_d == S_PUMP_B ? PUMP_B_SEQ[b_phase] : PUMP_B_IDLE;
            flush_en <= state_d == S_FLUSH;
            fcnt <= state == S_FLUSH ? fcnt + 1'b1 : '0;
            done_q <= (accept && cmd_op != OP_FLUSH && !a_start && !b_start) || (f_last && !abort);
        end
    end
endmodule
